mlp_layer_seq: RTL and testbench

- Parametrised, time-multiplexed successor to the fixed 4x4 fully-parallel MLP layer.
- One shared signed fixed-point MAC computes N_NEURONS outputs from N_INPUTS inputs, with per-neuron bias and selectable activation.
- Weights and biases sit in an internal register file loaded through a write port, not a flat weight bus.
- Sits between the VIO/host stimulus and the downstream layer, with valid/ready on input and output.

---
 rtl/mlp_pkg.sv | 46 ++++
 rtl/mlp_sigmoid_lut.sv | 47 ++++
 rtl/mlp_layer_seq.sv | 190 +++++++++++++++++++
 tb/tb_mlp_layer_seq.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// mlp_pkg -- shared definitions for the time-multiplexed MLP layer.
//   state_t      : controller states (IDLE, MAC, BIAS, ACT, DONE)
//   ACT_*        : act_mode encodings
//   acc_width()  : accumulator width that cannot overflow for a given
//                  sample width and fan-in
//   saturate()   : clamp a wide signed value to a dw-bit signed range
package mlp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAC,
    ST_BIAS,
    ST_ACT,
    ST_DONE
  } state_t;

  localparam logic [1:0] ACT_IDENT   = 2'd0;
  localparam logic [1:0] ACT_RELU    = 2'd1;
  localparam logic [1:0] ACT_SIGMOID = 2'd2;
  localparam logic [1:0] ACT_RSVD    = 2'd3;

  // Working width of saturate(); callers size-cast into and out of it.
  localparam int SAT_W = 128;

  // N_INPUTS full-scale products plus a bias term shifted into the
  // product's binary point, with one spare bit of headroom.
  function automatic int acc_width(input int dw, input int n_inputs);
    return 2 * dw + $clog2(n_inputs + 1) + 1;
  endfunction

  function automatic logic signed [SAT_W-1:0] saturate(
    input logic signed [SAT_W-1:0] v,
    input int                      dw
  );
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    one = SAT_W'(1);
    hi  = (one <<< (dw - 1)) - one;
    lo  = -(one <<< (dw - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/mlp_sigmoid_lut.sv
// mlp_sigmoid_lut -- 256-entry combinational sigmoid ROM.
//   idx_i : table index; entry k holds sigmoid((k-128)/16) in the output
//           fixed-point format, rounded to nearest (covers -8.0..+7.9375)
//   val_o : DATA_WIDTH-bit value with FRAC_BITS fractional bits
// The table is built at elaboration with integer arithmetic only
// (Q30 fixed point), so no real-valued math is needed by any tool.
module mlp_sigmoid_lut #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8
) (
  input  logic [7:0]            idx_i,
  output logic [DATA_WIDTH-1:0] val_o
);

  localparam longint ONE_Q  = 64'sd1 <<< 30;
  // exp(-1/16) in Q30; raising it to the k-th power gives exp(-k/16).
  localparam longint STEP_Q = 64'sd1008687096;

  function automatic logic [DATA_WIDTH-1:0] sig_entry(input int idx);
    longint e;
    longint s;
    longint v;
    longint lim;
    int     mag;
    mag = (idx >= 128) ? (idx - 128) : (128 - idx);
    e   = ONE_Q;
    for (int j = 0; j < mag; j++) e = (e * STEP_Q) >>> 30;
    // sigmoid(x) = 1/(1+exp(-x)) for x>=0, exp(x)/(1+exp(x)) for x<0,
    // both expressed through e = exp(-|x|) to keep values bounded.
    if (idx >= 128) s = (ONE_Q <<< 30) / (ONE_Q + e);
    else            s = (e <<< 30) / (ONE_Q + e);
    v   = ((s <<< FRAC_BITS) + (ONE_Q >>> 1)) >>> 30;
    lim = (64'sd1 <<< (DATA_WIDTH - 1)) - 1;
    if (v > lim) v = lim;
    return v[DATA_WIDTH-1:0];
  endfunction

  logic [DATA_WIDTH-1:0] rom [256];

  for (genvar g = 0; g < 256; g++) begin : g_rom
    localparam logic [DATA_WIDTH-1:0] ENTRY = sig_entry(g);
    assign rom[g] = ENTRY;
  end

  assign val_o = rom[idx_i];

endmodule

// File: rtl/mlp_layer_seq.sv
// mlp_layer_seq -- time-multiplexed fully-connected layer with one shared
// signed fixed-point MAC, per-neuron bias and selectable activation.
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/ready  : input vector handshake; layer_inputs element i at
//                     [i*DW +: DW], act_mode sampled with the vector
//   w_we/addr/data  : weight/bias write port, addr = n*(N_INPUTS+1)+i,
//                     i == N_INPUTS selects the bias of neuron n
//   busy            : a vector is being computed
//   out_valid/ready : output vector handshake; neuron n at [n*DW +: DW]
module mlp_layer_seq
  import mlp_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int N_INPUTS   = 4,
  parameter int N_NEURONS  = 4,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [N_INPUTS*DATA_WIDTH-1:0]  layer_inputs,
  input  logic [1:0]                      act_mode,
  input  logic                            w_we,
  input  logic [ADDR_WIDTH-1:0]           w_addr,
  input  logic [DATA_WIDTH-1:0]           w_data,
  output logic                            busy,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [N_NEURONS*DATA_WIDTH-1:0] layer_outputs
);

  localparam int DW     = DATA_WIDTH;
  localparam int ACC_W  = acc_width(DW, N_INPUTS);
  localparam int DEPTH  = N_NEURONS * (N_INPUTS + 1);
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW     = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int NW     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

  localparam logic [IW-1:0]         I_LAST  = IW'(N_INPUTS - 1);
  localparam logic [NW-1:0]         N_LAST  = NW'(N_NEURONS - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

  state_t                    state_q, state_d;
  logic [IW-1:0]             i_q, i_d;
  logic [NW-1:0]             n_q, n_d;
  logic [MEM_AW-1:0]         addr_q, addr_d;
  logic [N_NEURONS*DW-1:0]   out_q, out_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [DW-1:0]      x_q [N_INPUTS];
  logic [1:0]                mode_q;
  logic signed [DW-1:0]      wmem_q [DEPTH];

  logic                      accept;
  logic signed [DW-1:0]      x_sel;
  logic signed [DW-1:0]      w_sel;
  logic signed [2*DW-1:0]    prod;
  logic signed [ACC_W-1:0]   bias_term;
  logic signed [ACC_W-1:0]   acc_sh;
  logic signed [DW-1:0]      y_sat;
  logic signed [DW-1:0]      y_shr;
  logic signed [DW:0]        idx_wide;
  logic [7:0]                sig_idx;
  logic [DW-1:0]             sig_val;
  logic signed [DW-1:0]      y_act;

  assign in_ready      = (state_q == ST_IDLE);
  assign busy          = (state_q == ST_MAC) || (state_q == ST_BIAS) || (state_q == ST_ACT);
  assign out_valid     = (state_q == ST_DONE);
  assign layer_outputs = out_q;
  assign accept        = in_valid && in_ready;

  // addr_q walks weights then bias of each neuron in order, so the next
  // neuron's first weight follows directly after the previous bias.
  assign x_sel     = x_q[i_q];
  assign w_sel     = wmem_q[addr_q];
  assign prod      = x_sel * w_sel;
  assign bias_term = ACC_W'(w_sel) <<< FRAC_BITS;

  assign acc_sh = acc_q >>> FRAC_BITS;
  assign y_sat  = DW'(saturate(SAT_W'(acc_sh), DW));

  // Sigmoid index: 1/16 steps around a centre of 128, clamped to 0..255.
  assign y_shr    = y_sat >>> (FRAC_BITS - 4);
  assign idx_wide = {y_shr[DW-1], y_shr} + (DW+1)'(128);

  always_comb begin
    sig_idx = idx_wide[7:0];
    if (idx_wide[DW])            sig_idx = 8'd0;
    else if (|idx_wide[DW-1:8])  sig_idx = 8'd255;
  end

  mlp_sigmoid_lut #(
    .DATA_WIDTH (DW),
    .FRAC_BITS  (FRAC_BITS)
  ) u_sigmoid_lut (
    .idx_i (sig_idx),
    .val_o (sig_val)
  );

  always_comb begin
    y_act = y_sat;
    case (mode_q)
      ACT_RELU:           y_act = y_sat[DW-1] ? '0 : y_sat;
      ACT_SIGMOID:        y_act = sig_val;
      ACT_IDENT, ACT_RSVD: y_act = y_sat;
      default:            y_act = y_sat;
    endcase
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    n_d     = n_q;
    addr_d  = addr_q;
    acc_d   = acc_q;
    out_d   = out_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_MAC;
          i_d     = '0;
          n_d     = '0;
          addr_d  = '0;
          acc_d   = '0;
        end
      end
      ST_MAC: begin
        acc_d  = acc_q + ACC_W'(prod);
        addr_d = addr_q + 1'b1;
        if (i_q == I_LAST) state_d = ST_BIAS;
        else               i_d     = i_q + 1'b1;
      end
      ST_BIAS: begin
        acc_d   = acc_q + bias_term;
        addr_d  = addr_q + 1'b1;
        state_d = ST_ACT;
      end
      ST_ACT: begin
        for (int k = 0; k < N_NEURONS; k++) begin
          if (n_q == NW'(k)) out_d[k*DW +: DW] = y_act;
        end
        if (n_q == N_LAST) begin
          state_d = ST_DONE;
        end else begin
          n_d     = n_q + 1'b1;
          i_d     = '0;
          acc_d   = '0;
          state_d = ST_MAC;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      n_q     <= '0;
      addr_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      n_q     <= n_d;
      addr_q  <= addr_d;
      out_q   <= out_d;
    end
  end

  // Datapath registers: no reset, every vector starts from a cleared acc.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    if (accept) begin
      mode_q <= act_mode;
      for (int k = 0; k < N_INPUTS; k++) x_q[k] <= layer_inputs[k*DW +: DW];
    end
  end

  // Writes are dropped while busy so a computation sees one weight set.
  always_ff @(posedge clk) begin
    if (w_we && !busy && (w_addr < DEPTH_A)) wmem_q[w_addr[MEM_AW-1:0]] <= w_data;
  end

endmodule

// File: tb/tb_mlp_layer_seq.sv
module tb_mlp_layer_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] layer_inputs = '0;
  logic [1:0]  act_mode = '0;
  logic        w_we = 1'b0;
  logic [7:0]  w_addr = '0;
  logic [15:0] w_data = '0;
  logic        busy;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] layer_outputs;

  int n_tests = 0;
  int n_fail  = 0;

  mlp_layer_seq #(
    .DATA_WIDTH (16),
    .FRAC_BITS  (8),
    .N_INPUTS   (4),
    .N_NEURONS  (4),
    .ADDR_WIDTH (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .layer_inputs  (layer_inputs),
    .act_mode      (act_mode),
    .w_we          (w_we),
    .w_addr        (w_addr),
    .w_data        (w_data),
    .busy          (busy),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .layer_outputs (layer_outputs)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [63:0] w;   // weights of every neuron, input i at [i*16 +: 16]
    logic [15:0] b;   // bias of every neuron
    logic [63:0] x;   // input vector
    logic [1:0]  m;   // act_mode
    logic [15:0] e;   // expected value of every output slot
  } vec_t;

  vec_t tbl [13];

  function automatic logic [63:0] pk(input logic [15:0] a, input logic [15:0] b,
                                     input logic [15:0] c, input logic [15:0] d);
    return {d, c, b, a};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    w_we   = 1'b1;
    w_addr = a;
    w_data = d;
    step();
    w_we   = 1'b0;
  endtask

  task automatic load_uniform(input logic [63:0] w, input logic [15:0] b);
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 4; i++) wr(8'(n * 5 + i), w[i*16 +: 16]);
      wr(8'(n * 5 + 4), b);
    end
  endtask

  // Returns right after the accepting edge (edge 0).
  task automatic start(input logic [63:0] xv, input logic [1:0] m);
    int cnt;
    layer_inputs = xv;
    act_mode     = m;
    in_valid     = 1'b1;
    cnt          = 0;
    while (!in_ready && cnt < 100) begin
      step();
      cnt++;
    end
    if (!in_ready) chk("start_in_ready_timeout", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      step();
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    int          lat;
    int          bad_stable;
    int          ir_hi;
    int          ov_lo;
    int          ov_seen;
    logic [63:0] snap;

    // Reset state
    repeat (3) step();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_outputs", layer_outputs, 64'd0);
    rst = 1'b0;
    step();

    // Table: every neuron shares the weights, so every slot expects e.
    tbl[0]  = '{pk(16'h0100, 16'h0100, 16'h0100, 16'h0100), 16'h0000,
                pk(16'h0100, 16'h0200, 16'h0300, 16'h0400), 2'd0, 16'h0A00};
    tbl[1]  = '{pk(16'h0100, 16'h0000, 16'h0000, 16'h0000), 16'hFE00,
                pk(16'h0100, 16'h0000, 16'h0000, 16'h0000), 2'd0, 16'hFF00};
    tbl[2]  = '{pk(16'h0100, 16'h0000, 16'h0000, 16'h0000), 16'hFE00,
                pk(16'h0100, 16'h0000, 16'h0000, 16'h0000), 2'd1, 16'h0000};
    tbl[3]  = '{pk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF), 16'h0000,
                pk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF), 2'd0, 16'h7FFF};
    tbl[4]  = '{pk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF), 16'h0000,
                pk(16'h8000, 16'h8000, 16'h8000, 16'h8000), 2'd0, 16'h8000};
    tbl[5]  = '{pk(16'h0000, 16'h0000, 16'h0000, 16'h0000), 16'h0000,
                pk(16'h0100, 16'h0200, 16'h0300, 16'h0400), 2'd2, 16'h0080};
    tbl[6]  = '{pk(16'h0100, 16'h0000, 16'h0000, 16'h0000), 16'h0000,
                pk(16'h0A00, 16'h0000, 16'h0000, 16'h0000), 2'd2, 16'h0100};
    tbl[7]  = '{pk(16'h0100, 16'h0000, 16'h0000, 16'h0000), 16'h0000,
                pk(16'hF600, 16'h0000, 16'h0000, 16'h0000), 2'd2, 16'h0000};
    tbl[8]  = '{pk(16'h0100, 16'h0000, 16'h0000, 16'h0000), 16'hFE00,
                pk(16'h0100, 16'h0000, 16'h0000, 16'h0000), 2'd3, 16'hFF00};
    tbl[9]  = '{pk(16'h0100, 16'h0100, 16'h0100, 16'h0100), 16'h0100,
                pk(16'h0080, 16'h0080, 16'h0000, 16'h0000), 2'd1, 16'h0200};
    tbl[10] = '{pk(16'h0100, 16'h0000, 16'h0000, 16'h0000), 16'h0000,
                pk(16'h0100, 16'h0000, 16'h0000, 16'h0000), 2'd2, 16'h00BB};
    tbl[11] = '{pk(16'h0100, 16'h0000, 16'h0000, 16'h0000), 16'h0000,
                pk(16'hFF00, 16'h0000, 16'h0000, 16'h0000), 2'd2, 16'h0045};
    tbl[12] = '{pk(16'h0080, 16'h0000, 16'h0000, 16'h0000), 16'h0000,
                pk(16'hFFFF, 16'h0000, 16'h0000, 16'h0000), 2'd0, 16'hFFFF};

    for (int k = 0; k < 13; k++) begin
      load_uniform(tbl[k].w, tbl[k].b);
      start(tbl[k].x, tbl[k].m);
      wait_done(lat);
      chk($sformatf("vec%0d_latency", k), 64'(lat), 64'd24);
      for (int n = 0; n < 4; n++)
        chk($sformatf("vec%0d_n%0d", k, n), 64'(layer_outputs[n*16 +: 16]), 64'(tbl[k].e));
      release_out();
    end

    // Backpressure: distinct per-neuron weights check slot ordering too.
    for (int n = 0; n < 4; n++) begin
      wr(8'(n * 5), 16'((n + 1) * 256));
      for (int i = 1; i < 5; i++) wr(8'(n * 5 + i), 16'h0000);
    end
    start(pk(16'h0100, 16'h0000, 16'h0000, 16'h0000), 2'd0);
    wait_done(lat);
    chk("bp_latency", 64'(lat), 64'd24);
    chk("bp_out1", layer_outputs, 64'h0400_0300_0200_0100);
    snap         = layer_outputs;
    layer_inputs = pk(16'h0200, 16'h0000, 16'h0000, 16'h0000);
    in_valid     = 1'b1;
    bad_stable   = 0;
    ir_hi        = 0;
    ov_lo        = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (layer_outputs !== snap) bad_stable++;
      if (in_ready || busy) ir_hi++;
      if (!out_valid) ov_lo++;
    end
    chk("bp_hold_stable", 64'(bad_stable), 64'd0);
    chk("bp_hold_not_ready", 64'(ir_hi), 64'd0);
    chk("bp_hold_out_valid", 64'(ov_lo), 64'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_hs_in_ready", 64'(in_ready), 64'd1);
    chk("bp_hs_out_valid", 64'(out_valid), 64'd0);
    chk("bp_hs_busy", 64'(busy), 64'd0);
    step();
    in_valid = 1'b0;
    chk("bp_accept_busy", 64'(busy), 64'd1);
    chk("bp_accept_in_ready", 64'(in_ready), 64'd0);
    wait_done(lat);
    chk("bp2_latency", 64'(lat), 64'd24);
    chk("bp_out2", layer_outputs, 64'h0800_0600_0400_0200);
    release_out();

    // Writes while busy are dropped; writes in DONE land; out-of-range ignored.
    load_uniform(pk(16'h0100, 16'h0100, 16'h0100, 16'h0100), 16'h0000);
    start(pk(16'h0100, 16'h0200, 16'h0300, 16'h0400), 2'd0);
    wr(8'd0, 16'h0500);
    wr(8'd4, 16'h0300);
    wait_done(lat);
    chk("wbusy_out", layer_outputs, 64'h0A00_0A00_0A00_0A00);
    wr(8'd0, 16'h0200);
    wr(8'h80, 16'h7FFF);
    release_out();
    start(pk(16'h0100, 16'h0200, 16'h0300, 16'h0400), 2'd0);
    wait_done(lat);
    chk("wdone_out", layer_outputs, 64'h0A00_0A00_0A00_0B00);
    release_out();

    // Reset mid-computation
    start(pk(16'h0100, 16'h0200, 16'h0300, 16'h0400), 2'd0);
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_outputs", layer_outputs, 64'd0);
    ov_seen = 0;
    repeat (30) begin
      step();
      if (out_valid) ov_seen++;
    end
    chk("midrst_no_out_valid", 64'(ov_seen), 64'd0);
    start(pk(16'h0100, 16'h0200, 16'h0300, 16'h0400), 2'd0);
    wait_done(lat);
    chk("midrst_rerun_latency", 64'(lat), 64'd24);
    chk("midrst_weights_kept", layer_outputs, 64'h0A00_0A00_0A00_0B00);
    release_out();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
